// File: rtl/slowctrl_pkg.sv
// Shared types and constants for the slow-FPGA command arbiter.
// The cmd_t layout pins page/addr widths to the default geometry below.
package slowctrl_pkg;

  localparam int DEF_PAGE_NUM       = 5;
  localparam int DEF_PAGE_AW        = 10;
  localparam int DEF_FIFO_AW        = 4;
  localparam int DEF_TTLIN_NUM      = 6;
  localparam int DEF_TTLOUT_NUM     = 10;
  localparam int DEF_ENC_NUM        = 4;
  localparam int DEF_REFRESH_CYCLES = 125000;
  localparam logic [DEF_PAGE_NUM+DEF_PAGE_AW-1:0] DEF_STATUS_ADDR = 15'h7FFF;

  // Status word: {pad, outenc, inenc, ttlout, ttlin}, LSB first.
  localparam int TTLIN_LSB  = 0;
  localparam int TTLOUT_LSB = TTLIN_LSB + DEF_TTLIN_NUM;
  localparam int INENC_LSB  = TTLOUT_LSB + DEF_TTLOUT_NUM;
  localparam int OUTENC_LSB = INENC_LSB + DEF_ENC_NUM;

  typedef struct packed {
    logic [DEF_PAGE_NUM-1:0] page;
    logic [DEF_PAGE_AW-1:0]  addr;
    logic [31:0]             data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/slowctrl_cmd_arbiter_if.sv
// Register-bus write port plus serialiser start/busy handshake.
interface slowctrl_cmd_arbiter_if #(
  parameter int MOD_COUNT = 32,
  parameter int PAGE_AW   = 10,
  parameter int TX_AW     = 15
);
  logic [MOD_COUNT-1:0] write_strobe;
  logic [PAGE_AW-1:0]   write_address;
  logic [31:0]          write_data;
  logic                 write_ack;
  logic                 tx_start;
  logic [TX_AW-1:0]     tx_address;
  logic [31:0]          tx_data;
  logic                 tx_busy;

  modport slave (
    input  write_strobe, write_address, write_data, tx_busy,
    output write_ack, tx_start, tx_address, tx_data
  );

  modport master (
    output write_strobe, write_address, write_data, tx_busy,
    input  write_ack, tx_start, tx_address, tx_data
  );
endinterface

// File: rtl/slowctrl_cmd_fifo.sv
// Synchronous command FIFO, fall-through head, registered count.
// Caller never pushes when full nor pops when empty.
module slowctrl_cmd_fifo #(
  parameter int W  = 47,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 2**AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/slowctrl_cmd_arbiter.sv
// Queues register writes and LED status frames for the slow-FPGA serialiser,
// alternating between the two sources, one frame per start/busy handshake.
module slowctrl_cmd_arbiter
  import slowctrl_pkg::*;
#(
  parameter int PAGE_NUM       = DEF_PAGE_NUM,
  parameter int PAGE_AW        = DEF_PAGE_AW,
  parameter int FIFO_AW        = DEF_FIFO_AW,
  parameter int TTLIN_NUM      = DEF_TTLIN_NUM,
  parameter int TTLOUT_NUM     = DEF_TTLOUT_NUM,
  parameter int ENC_NUM        = DEF_ENC_NUM,
  parameter logic [PAGE_NUM+PAGE_AW-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  slowctrl_cmd_arbiter_if.slave bus,
  input  logic                  overflow_clr_i,
  input  logic [TTLIN_NUM-1:0]  ttlin_i,
  input  logic [TTLOUT_NUM-1:0] ttlout_i,
  input  logic [ENC_NUM-1:0]    inenc_conn_i,
  input  logic [ENC_NUM-1:0]    outenc_conn_i,
  output logic [FIFO_AW:0]      fifo_count_o,
  output logic                  overflow_o
);
  localparam int MOD_COUNT = 2**PAGE_NUM;
  localparam int TX_AW     = PAGE_NUM + PAGE_AW;
  localparam int TMR_W     = $clog2(REFRESH_CYCLES + 1);

  // write capture
  logic                wr_valid;
  logic [PAGE_NUM-1:0] wr_page;
  logic                write_ack_q;

  always_comb begin
    wr_page = '0;
    for (int i = MOD_COUNT-1; i >= 0; i--)
      if (bus.write_strobe[i]) wr_page = PAGE_NUM'(i);
  end
  assign wr_valid = |bus.write_strobe;

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty, push_en, pop_en;

  assign push_cmd = '{page: wr_page, addr: bus.write_address, data: bus.write_data};
  assign push_en  = wr_valid && !fifo_full;

  slowctrl_cmd_fifo #(.W($bits(cmd_t)), .AW(FIFO_AW)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push      (push_en),
    .push_data (push_cmd),
    .pop       (pop_en),
    .head      (head_cmd),
    .count     (fifo_count_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Every presented write is acked so the bus never stalls; drops only flag overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      write_ack_q <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      write_ack_q <= wr_valid;
      if (wr_valid && fifo_full) overflow_o <= 1'b1;
      else if (overflow_clr_i)   overflow_o <= 1'b0;
    end
  end
  assign bus.write_ack = write_ack_q;

  // status tracking
  logic [31:0]      status_word, last_sent;
  logic             status_pending, refresh_hit, issue_status;
  logic [TMR_W-1:0] refresh_cnt;

  always_comb begin
    status_word = '0;
    status_word[TTLIN_LSB  +: TTLIN_NUM]  = ttlin_i;
    status_word[TTLOUT_LSB +: TTLOUT_NUM] = ttlout_i;
    status_word[INENC_LSB  +: ENC_NUM]    = inenc_conn_i;
    status_word[OUTENC_LSB +: ENC_NUM]    = outenc_conn_i;
  end

  assign refresh_hit = (refresh_cnt == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)          refresh_cnt <= TMR_W'(REFRESH_CYCLES - 1);
    else if (refresh_hit) refresh_cnt <= TMR_W'(REFRESH_CYCLES - 1);
    else                  refresh_cnt <= refresh_cnt - 1'b1;
  end

  // Issue clears pending; a change in that same cycle shows up against the new last_sent.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      status_pending <= 1'b1;
      last_sent      <= '0;
    end else if (issue_status) begin
      status_pending <= 1'b0;
      last_sent      <= status_word;
    end else if (status_word != last_sent || refresh_hit) begin
      status_pending <= 1'b1;
    end
  end

  // arbitration and frame sequencing
  state_e             state, state_nxt;
  logic               last_was_write, pick_status, pick_write, have_work;
  logic               load, tx_start;
  logic [TX_AW-1:0]   tx_address_q;
  logic [31:0]        tx_data_q;

  assign pick_status  = status_pending && (fifo_empty || last_was_write);
  assign pick_write   = !fifo_empty && !pick_status;
  assign have_work    = pick_status || pick_write;
  assign pop_en       = load && pick_write;
  assign issue_status = load && pick_status;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // ARM exists because the serialiser raises busy only the cycle after start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (have_work)   state_nxt = ST_ISSUE;
      ST_ISSUE:                  state_nxt = ST_ARM;
      ST_ARM:                    state_nxt = ST_WAIT;
      ST_WAIT:  if (!bus.tx_busy) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE:  load     = have_work;
      ST_ISSUE: tx_start = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_address_q   <= '0;
      tx_data_q      <= '0;
      last_was_write <= 1'b0;
    end else if (load) begin
      last_was_write <= pick_write;
      if (pick_write) begin
        tx_address_q <= {head_cmd.page, head_cmd.addr};
        tx_data_q    <= head_cmd.data;
      end else begin
        tx_address_q <= STATUS_ADDR;
        tx_data_q    <= status_word;
      end
    end
  end

  assign bus.tx_start   = tx_start;
  assign bus.tx_address = tx_address_q;
  assign bus.tx_data    = tx_data_q;
endmodule

// File: tb/tb_slowctrl_cmd_arbiter.sv
// Directed bench for slowctrl_cmd_arbiter: decode vector table plus
// hand sequences for timing, ordering, overflow and mid-frame reset.
module tb_slowctrl_cmd_arbiter;
  localparam int R = 400;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        overflow_clr_i = 1'b0;
  logic [5:0]  ttlin_i = '0;
  logic [9:0]  ttlout_i = '0;
  logic [3:0]  inenc_conn_i = '0;
  logic [3:0]  outenc_conn_i = '0;
  logic [4:0]  fifo_count_o;
  logic        overflow_o;

  slowctrl_cmd_arbiter_if #(.MOD_COUNT(32), .PAGE_AW(10), .TX_AW(15)) bus ();

  slowctrl_cmd_arbiter #(.REFRESH_CYCLES(R)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .bus           (bus),
    .overflow_clr_i(overflow_clr_i),
    .ttlin_i       (ttlin_i),
    .ttlout_i      (ttlout_i),
    .inenc_conn_i  (inenc_conn_i),
    .outenc_conn_i (outenc_conn_i),
    .fifo_count_o  (fifo_count_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  int cyc = 0, ack_cnt = 0, busy_left = 0;
  int busy_len = 0, fbase = 0, rel_cyc = 0;
  bit force_busy = 1'b0;
  logic [14:0] frm_addr[$];
  logic [31:0] frm_data[$];
  int          frm_cyc[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Frame monitor and serialiser model; busy rises half a cycle after start is seen.
  always @(negedge clk_i) begin
    if (bus.write_ack) ack_cnt++;
    if (reset_i) busy_left = 0;
    else if (bus.tx_start) begin
      frm_addr.push_back(bus.tx_address);
      frm_data.push_back(bus.tx_data);
      frm_cyc.push_back(cyc);
      busy_left = busy_len;
    end else if (busy_left > 0) busy_left--;
    bus.tx_busy = force_busy || (busy_left > 0);
  end

  typedef struct {
    logic [31:0] strobe;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [14:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vec [6];

  function automatic int nfr();
    return frm_addr.size() - fbase;
  endfunction

  function automatic logic [31:0] fa(int i);
    if (fbase + i < frm_addr.size()) return 32'(frm_addr[fbase+i]);
    return '1;
  endfunction

  function automatic logic [31:0] fd(int i);
    if (fbase + i < frm_data.size()) return frm_data[fbase+i];
    return 32'hDEAD_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wr(logic [31:0] strb, logic [9:0] a, logic [31:0] d, bit clr = 1'b0);
    bus.write_strobe = strb; bus.write_address = a; bus.write_data = d;
    overflow_clr_i = clr;
    tick();
    bus.write_strobe = '0; overflow_clr_i = 1'b0;
  endtask

  task automatic wait_frames(int n, int budget, string name);
    int k = 0;
    while (nfr() < n && k < budget) begin tick(); k++; end
    chk(name, nfr(), n);
  endtask

  task automatic do_reset(logic [31:0] exp_status);
    reset_i = 1'b1;
    tick(2);
    chk("rst_tx_start",   bus.tx_start,   0);
    chk("rst_tx_address", bus.tx_address, 0);
    chk("rst_tx_data",    bus.tx_data,    0);
    chk("rst_write_ack",  bus.write_ack,  0);
    chk("rst_fifo_count", fifo_count_o,   0);
    chk("rst_overflow",   overflow_o,     0);
    fbase = frm_addr.size();
    reset_i = 1'b0;
    rel_cyc = cyc;
    wait_frames(1, 10, "rst_first_frame");
    chk("rst_first_addr", fa(0), 32'h7FFF);
    chk("rst_first_data", fd(0), exp_status);
    tick(4);
    fbase = frm_addr.size();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ack_base;
    bus.write_strobe = '0; bus.write_address = '0; bus.write_data = '0;

    vec[0] = '{32'h0000_0008, 10'h3AA, 32'h55AA55AA, 15'h0FAA, 32'h55AA55AA};
    vec[1] = '{32'h0000_0005, 10'h355, 32'h12345678, 15'h0355, 32'h12345678};
    vec[2] = '{32'h8000_0000, 10'h3FF, 32'hDEADBEEF, 15'h7FFF, 32'hDEADBEEF};
    vec[3] = '{32'h0000_0001, 10'h000, 32'hFFFFFFFF, 15'h0000, 32'hFFFFFFFF};
    vec[4] = '{32'hFFFF_0000, 10'h001, 32'hA5A50001, 15'h4001, 32'hA5A50001};
    vec[5] = '{32'h0000_0300, 10'h2C0, 32'h00000001, 15'h22C0, 32'h00000001};

    // reset release: one status frame, then silence until the refresh period
    do_reset(32'h0);
    while (cyc - rel_cyc < R - 20) tick();
    chk("no_early_refresh", nfr(), 0);
    wait_frames(1, 40, "refresh_frame");
    chk("refresh_addr", fa(0), 32'h7FFF);
    chk("refresh_data", fd(0), 32'h0);

    // page decode table
    do_reset(32'h0);
    for (int i = 0; i < 6; i++) begin
      fbase = frm_addr.size();
      wr(vec[i].strobe, vec[i].addr, vec[i].data);
      chk($sformatf("vec%0d_ack", i), bus.write_ack, 1);
      tick();
      chk($sformatf("vec%0d_ack_once", i), bus.write_ack, 0);
      wait_frames(1, 10, $sformatf("vec%0d_frame", i));
      chk($sformatf("vec%0d_addr", i), fa(0), 32'(vec[i].exp_addr));
      chk($sformatf("vec%0d_data", i), fd(0), vec[i].exp_data);
      tick(6);
    end

    // busy held for 40 cycles after ARM: start-to-start gap of 43
    do_reset(32'h0);
    busy_len = 41;
    wr(32'h1, 10'h001, 32'h1);
    wr(32'h1, 10'h002, 32'h2);
    wait_frames(2, 120, "busy_frames");
    if (nfr() >= 2) chk("busy_gap", frm_cyc[fbase+1] - frm_cyc[fbase], 43);
    chk("busy_second_data", fd(1), 32'h2);
    busy_len = 0;
    tick(50);

    // status change while writes queue: W, S, W, W
    do_reset(32'h0);
    ttlin_i = 6'h01;
    wr(32'h2, 10'h011, 32'hA1);
    wr(32'h4, 10'h022, 32'hA2);
    wr(32'h8, 10'h033, 32'hA3);
    wait_frames(4, 60, "order_frames");
    chk("order0_addr", fa(0), 32'h0411);
    chk("order0_data", fd(0), 32'hA1);
    chk("order1_addr", fa(1), 32'h7FFF);
    chk("order1_data", fd(1), 32'h1);
    chk("order2_addr", fa(2), 32'h0822);
    chk("order3_addr", fa(3), 32'h0C33);

    // field placement of every status source
    tick(6);
    fbase = frm_addr.size();
    inenc_conn_i = 4'hA; outenc_conn_i = 4'h5; ttlout_i = 10'h3FF;
    wait_frames(1, 20, "enc_frame");
    chk("enc_addr", fa(0), 32'h7FFF);
    chk("enc_data", fd(0), 32'h005AFFC1);
    tick(10);
    chk("enc_single", nfr(), 1);
    ttlin_i = '0; ttlout_i = '0; inenc_conn_i = '0; outenc_conn_i = '0;

    // overflow: serialiser stuck busy with one frame in flight
    do_reset(32'h0);
    force_busy = 1'b1;
    wr(32'h1, 10'h3F0, 32'hD0);
    wait_frames(1, 10, "ovf_w0_frame");
    tick(3);
    fbase = frm_addr.size();
    ack_base = ack_cnt;
    for (int i = 0; i < 17; i++) begin
      wr(32'h1, 10'(i), 32'h100 + i);
      if (i == 15) begin
        chk("ovf_full_count", fifo_count_o, 16);
        chk("ovf_not_yet", overflow_o, 0);
      end
    end
    tick();
    chk("ovf_count_sat", fifo_count_o, 16);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_acks", ack_cnt - ack_base, 17);
    wr(32'h1, 10'h3F, 32'hBAD, 1'b1);
    chk("ovf_set_wins", overflow_o, 1);
    overflow_clr_i = 1'b1;
    tick();
    overflow_clr_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);
    force_busy = 1'b0;
    wait_frames(16, 200, "drain_frames");
    chk("drain_first", fd(0), 32'h100);
    chk("drain_last", fd(15), 32'h10F);
    tick(10);
    chk("drain_no_extra", nfr(), 16);
    chk("drain_count", fifo_count_o, 0);

    // reset during WAIT
    do_reset(32'h0);
    force_busy = 1'b1;
    wr(32'h1, 10'h001, 32'hE0);
    wait_frames(1, 10, "wrst_w0_frame");
    wr(32'h1, 10'h002, 32'hE1);
    wr(32'h1, 10'h003, 32'hE2);
    wr(32'h1, 10'h004, 32'hE3);
    tick();
    chk("wrst_pre_count", fifo_count_o, 3);
    #2 reset_i = 1'b1;
    #1;
    chk("wrst_tx_start", bus.tx_start, 0);
    chk("wrst_fifo_count", fifo_count_o, 0);
    force_busy = 1'b0;
    tick(2);
    fbase = frm_addr.size();
    reset_i = 1'b0;
    wait_frames(1, 10, "wrst_first_frame");
    chk("wrst_first_addr", fa(0), 32'h7FFF);
    chk("wrst_first_data", fd(0), 32'h0);
    tick(20);
    chk("wrst_fifo_discarded", nfr(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/slowctrl_cmd_arbiter.md
Name: slowctrl_cmd_arbiter

Overview:
Sits on the fast-FPGA side, between the register bus (paged write strobes) and the SPI serialiser that talks to the slow FPGA. It buffers register writes in a command FIFO and generates status frames carrying the TTL and encoder-connection state. These status frames drive the slow-FPGA LEDs. The block arbitrates between the two sources and sequences the serialiser through a start/busy handshake, one frame at a time.

Parameters:
PAGE_NUM, 5, page-select bits; MOD_COUNT = 2**PAGE_NUM strobe lines
PAGE_AW, 10, register address bits within a page
FIFO_AW, 4, log2 of command FIFO depth (16 entries)
TTLIN_NUM, 6, TTL input count
TTLOUT_NUM, 10, TTL output count
ENC_NUM, 4, encoder channel count
STATUS_ADDR, 15'h7FFF, frame address used for status frames
REFRESH_CYCLES, 125000, forced status-resend period in clk_i cycles (1 ms at 125 MHz)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
write_strobe_i  in  MOD_COUNT  one-hot page write strobe
write_address_i  in  PAGE_AW  register address
write_data_i  in  32  register data
write_ack_o  out  1  write acknowledge pulse
overflow_clr_i  in  1  clears overflow_o
ttlin_i  in  TTLIN_NUM  TTL input levels
ttlout_i  in  TTLOUT_NUM  TTL output levels
inenc_conn_i  in  ENC_NUM  input-encoder connected flags
outenc_conn_i  in  ENC_NUM  output-encoder connected flags
tx_start_o  out  1  frame start pulse to serialiser
tx_address_o  out  PAGE_NUM+PAGE_AW  frame address
tx_data_o  out  32  frame data
tx_busy_i  in  1  serialiser busy
fifo_count_o  out  FIFO_AW+1  FIFO occupancy
overflow_o  out  1  sticky flag: a write was dropped

Behaviour:
- Reset values: all outputs 0. FIFO empty. last_sent = 0. status_pending = 1, so the first frame after reset is a status frame. Refresh timer loaded with REFRESH_CYCLES-1.
- Reset mid-frame: the FSM returns to IDLE immediately. Any FIFO contents are discarded. No retry is attempted.
- Write capture: any strobe bit high in cycle N means a write is presented. The lowest set bit index is the page p. The FIFO entry is {p, write_address_i, write_data_i}.
  - write_ack_o pulses in cycle N+1 for every presented write, whether it is accepted or dropped, so the bus never stalls.
  - If the registered count equals 2**FIFO_AW at cycle N, the write is dropped and overflow_o is set. A pop in the same cycle does not free space for that write.
- overflow_o stays set until overflow_clr_i is high. If a drop and a clear happen in the same cycle, set wins.
- Status word: {8'b0, outenc_conn_i, inenc_conn_i, ttlout_i, ttlin_i}, zero-padded to 32 bits.
  - status_pending is set when the live word differs from last_sent, or when the refresh timer reaches 0. The timer reloads on reaching 0.
  - When a status frame issues, the live word is snapshotted into both tx_data_o and last_sent, and status_pending is cleared. A change during that same cycle is caught on the next comparison.
- Arbitration: alternating priority. After a write frame, a pending status frame wins. After a status frame, a non-empty FIFO wins. If only one source has work, that source goes.
- FSM:
  - IDLE: if work is available, load tx_address_o/tx_data_o and go to ISSUE. A FIFO pop happens on this transition.
  - ISSUE: tx_start_o = 1 for exactly one cycle. Go to ARM.
  - ARM: one cycle in which tx_busy_i is ignored, because the serialiser raises busy the cycle after start. Go to WAIT.
  - WAIT: stay while tx_busy_i = 1. Go to IDLE on the first cycle it is 0.
  - Minimum frame spacing is therefore 4 cycles start-to-start.
- tx_address_o and tx_data_o hold their values from IDLE exit until the next load.
- fifo_count_o is registered and updates the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.

Decomposition:
- Package slowctrl_pkg holds:
  - the cmd_t record {page, addr, data};
  - the status-word field offsets;
  - the FSM state type;
  - the STATUS_ADDR default.
- Sub-module slowctrl_cmd_fifo: synchronous FIFO with registered count, and full/empty derived from the count. The arbiter FSM and the status tracker live in the top level.

Test Plan:
- Reset release with idle inputs: exactly one status frame is sent, tx_address_o = 15'h7FFF and tx_data_o = 0. No further frame follows until REFRESH_CYCLES elapses.
- write_strobe_i = 32'h8, address 10'h3AA, data 32'h55AA55AA: write_ack_o pulses in the next cycle, and a frame issues with tx_address_o = 15'h0FAA and tx_data_o = 32'h55AA55AA. A serialiser model holding busy for 40 cycles yields the next tx_start_o no earlier than 43 cycles later.
- write_strobe_i = 32'h5 with address 10'h355: the lowest bit wins, giving tx_address_o = 15'h0355.
- Toggle ttlin_i[0] while 3 writes are queued: frame order is W, S, W, W. The status frame carries tx_data_o = 32'h1.
- Hold tx_busy_i = 1 and push 17 writes: fifo_count_o saturates at 16 and overflow_o = 1. All 17 write_ack_o pulses are seen. overflow_clr_i clears the flag.
- Assert reset_i during WAIT: tx_start_o and fifo_count_o read 0 immediately. The first post-reset frame is status.
